// File: rtl/fifo_write_logic.sv
// Write-domain half of the dual-clock FIFO: write pointer, RAM strobe,
// Gray pointer export and full/almost-full/level/overflow status.
module fifo_write_logic #(
  parameter int DEPTH    = 4,
  parameter int PTR_SZ   = 2,
  parameter int AF_LEVEL = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [PTR_SZ:0]   wq2_rptr_gray,
  output logic              write_en,
  output logic [PTR_SZ-1:0] waddr,
  output logic [PTR_SZ:0]   wptr_gray,
  output logic              wfull,
  output logic              almost_full,
  output logic [PTR_SZ:0]   wcount,
  output logic              wovf
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] WRITE = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;

  localparam int AF_CLAMP = (AF_LEVEL > DEPTH) ? DEPTH : AF_LEVEL;
  localparam logic [PTR_SZ:0] AF_THR = (PTR_SZ+1)'(AF_CLAMP);
  localparam logic [PTR_SZ:0] TOP2 = {2'b11, {(PTR_SZ-1){1'b0}}};

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [PTR_SZ:0] wbin;
  logic [PTR_SZ:0] wbin_nxt;
  logic [PTR_SZ:0] wgray_nxt;
  logic [PTR_SZ:0] rbin;
  logic [PTR_SZ:0] wcount_nxt;
  logic            full_nxt;
  logic            accept;

  // The FULL state is the single full flag.
  assign wfull    = (state == FULL);
  assign accept   = winc & ~wfull;
  assign write_en = accept;

  assign wbin_nxt  = wbin + {{PTR_SZ{1'b0}}, accept};
  assign wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1);

  always_comb begin
    rbin = '0;
    for (int i = 0; i <= PTR_SZ; i++) begin
      rbin[i] = ^(wq2_rptr_gray >> i);
    end
  end

  assign full_nxt   = (wgray_nxt == (wq2_rptr_gray ^ TOP2));
  assign wcount_nxt = wbin_nxt - rbin;

  always_comb begin
    state_nxt = IDLE;
    if (state == 2'b11) begin
      state_nxt = IDLE;
    end else if (full_nxt) begin
      state_nxt = FULL;
    end else if (wcount_nxt == '0) begin
      state_nxt = IDLE;
    end else begin
      state_nxt = WRITE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wbin        <= '0;
      waddr       <= '0;
      wptr_gray   <= '0;
      wcount      <= '0;
      almost_full <= 1'b0;
      wovf        <= 1'b0;
    end else begin
      state       <= state_nxt;
      wbin        <= wbin_nxt;
      waddr       <= wbin_nxt[PTR_SZ-1:0];
      wptr_gray   <= wgray_nxt;
      wcount      <= wcount_nxt;
      almost_full <= (wcount_nxt >= AF_THR);
      if (winc & wfull) begin
        wovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_logic.sv
// Bench for fifo_write_logic: occupancy model checked every cycle
// plus directed fill/overflow/drain/wrap/reset vectors.
module tb_fifo_write_logic;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       winc = 1'b0;
  logic [2:0] wq2 = 3'b000;
  logic       write_en;
  logic [1:0] waddr;
  logic [2:0] wptr_gray;
  logic       wfull;
  logic       almost_full;
  logic [2:0] wcount;
  logic       wovf;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_write_logic #(.DEPTH(4), .PTR_SZ(2), .AF_LEVEL(3)) dut (
    .clk(clk),
    .rst(rst),
    .winc(winc),
    .wq2_rptr_gray(wq2),
    .write_en(write_en),
    .waddr(waddr),
    .wptr_gray(wptr_gray),
    .wfull(wfull),
    .almost_full(almost_full),
    .wcount(wcount),
    .wovf(wovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] to_gray(input int b);
    logic [2:0] v;
    v = 3'(b);
    return v ^ (v >> 1);
  endfunction

  // Model: count of accepted writes and occupancy against the read pointer.
  bit m_valid = 0;
  int m_wr, m_cnt, m_state;
  bit m_full, m_af, m_ovf;

  function automatic int from_gray(input logic [2:0] g);
    for (int b = 0; b < 8; b++) begin
      if (to_gray(b) == g) return b;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    int rd;
    if (rst) begin
      m_valid = 1;
      m_wr = 0; m_cnt = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else if (m_valid) begin
      if (winc && m_full) m_ovf = 1;
      if (winc && !m_full) m_wr = (m_wr + 1) % 8;
      rd = from_gray(wq2);
      m_cnt = (m_wr - rd + 8) % 8;
      m_full = (m_cnt == 4);
      m_af = (m_cnt >= 3);
    end
    m_state = m_full ? 2 : (m_cnt == 0 ? 0 : 1);
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_write_en", int'(write_en), int'(winc && !m_full));
      chk("m_waddr", int'(waddr), m_wr % 4);
      chk("m_wptr_gray", int'(wptr_gray), int'(to_gray(m_wr)));
      chk("m_wfull", int'(wfull), int'(m_full));
      chk("m_almost_full", int'(almost_full), int'(m_af));
      chk("m_wcount", int'(wcount), m_cnt);
      chk("m_wovf", int'(wovf), int'(m_ovf));
      chk("m_state", int'(dut.state), m_state);
    end
  end

  task automatic pre(input bit r, input bit w, input logic [2:0] q);
    rst = r; winc = w; wq2 = q;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] gexp [4];
    logic [2:0] prev;
    int w;
    gexp[0] = 3'b001; gexp[1] = 3'b011;
    gexp[2] = 3'b010; gexp[3] = 3'b110;

    // reset held with winc high
    rst = 1; winc = 1; wq2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wcount", int'(wcount), 0);
    chk("rst_gray", int'(wptr_gray), 0);
    chk("rst_wfull", int'(wfull), 0);
    chk("rst_state", int'(dut.state), 0);
    pre(0, 0, 3'b000);
    tick();
    chk("rel_waddr", int'(waddr), 0);
    chk("rel_wcount", int'(wcount), 0);

    // fill
    for (int k = 0; k < 4; k++) begin
      pre(0, 1, 3'b000);
      chk("fill_we", int'(write_en), 1);
      chk("fill_waddr", int'(waddr), k);
      tick();
      chk("fill_gray", int'(wptr_gray), int'(gexp[k]));
      chk("fill_cnt", int'(wcount), k + 1);
      chk("fill_af", int'(almost_full), int'(k >= 2));
      chk("fill_full", int'(wfull), int'(k == 3));
    end

    // overflow
    for (int k = 0; k < 2; k++) begin
      pre(0, 1, 3'b000);
      chk("ovf_we", int'(write_en), 0);
      tick();
      chk("ovf_gray", int'(wptr_gray), 6);
      chk("ovf_waddr", int'(waddr), 0);
      chk("ovf_flag", int'(wovf), 1);
    end
    pre(0, 0, 3'b000);
    tick();
    chk("ovf_sticky", int'(wovf), 1);

    // drain one slot then refill
    pre(0, 0, 3'b001);
    tick();
    chk("drain_full", int'(wfull), 0);
    chk("drain_cnt", int'(wcount), 3);
    pre(0, 1, 3'b001);
    chk("refill_waddr", int'(waddr), 0);
    tick();
    chk("refill_gray", int'(wptr_gray), 7);
    chk("refill_full", int'(wfull), 1);

    // wrap, reader two behind
    pre(0, 0, to_gray(3));
    tick();
    chk("wrap0_cnt", int'(wcount), 2);
    chk("wrap0_full", int'(wfull), 0);
    for (int i = 0; i < 12; i++) begin
      w = (5 + i) % 8;
      pre(0, 1, to_gray((w + 7) % 8));
      chk("wrap_we", int'(write_en), 1);
      chk("wrap_waddr", int'(waddr), w % 4);
      prev = wptr_gray;
      tick();
      chk("wrap_gray1bit", $countones(prev ^ wptr_gray), 1);
      chk("wrap_cnt", int'(wcount), 2);
      chk("wrap_full", int'(wfull), 0);
    end

    // mid-operation reset at level 3
    pre(0, 1, to_gray(7));
    tick();
    chk("mid_cnt", int'(wcount), 3);
    pre(1, 0, to_gray(7));
    tick();
    chk("mrst_cnt", int'(wcount), 0);
    chk("mrst_gray", int'(wptr_gray), 0);
    chk("mrst_waddr", int'(waddr), 0);
    chk("mrst_af", int'(almost_full), 0);
    chk("mrst_ovf", int'(wovf), 0);
    chk("mrst_state", int'(dut.state), 0);
    pre(0, 0, 3'b000);
    tick();
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
